// File: rtl/input_unit_if.sv
// input_unit_if: operator-entry bus between the keypad/CPU side and input_unit.
// Carries the switch digit, raw buttons, CPU load strobe and the value/status returned.
interface input_unit_if;
    logic [3:0] key_digit;
    logic       key_push;
    logic       key_enter;
    logic       li;
    logic [7:0] data_out;
    logic       ready;
    logic       err;
    logic [7:0] disp_bcd;

    // Operator/CPU side: drives buttons, digit and li; observes the result.
    modport master (
        output key_digit,
        output key_push,
        output key_enter,
        output li,
        input  data_out,
        input  ready,
        input  err,
        input  disp_bcd
    );

    // Entry unit side.
    modport slave (
        input  key_digit,
        input  key_push,
        input  key_enter,
        input  li,
        output data_out,
        output ready,
        output err,
        output disp_bcd
    );
endinterface

// File: rtl/input_unit.sv
// input_unit: two-digit decimal entry front end with button sync/debounce and li handshake.
// Ports: clk, rst (sync, active high), bus (input_unit_if.slave: digit, buttons, li, value/status).
module input_unit #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 16
) (
    input  logic         clk,
    input  logic         rst,
    input_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ONE,
        S_TWO,
        S_FULL
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Index 0 = digit button, index 1 = enter button.
    logic [1:0]       raw;
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [1:0]       db_q;
    logic [1:0]       db_d;
    logic [1:0]       db_prev_q;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [1:0]       press;
    logic             push_p;
    logic             enter_p;

    state_e           state_q;
    state_e           state_d;
    logic [3:0]       tens_q;
    logic [3:0]       tens_d;
    logic [3:0]       ones_q;
    logic [3:0]       ones_d;
    logic [7:0]       data_q;
    logic [7:0]       data_d;
    logic             ready_q;
    logic             ready_d;
    logic             err_q;
    logic             err_d;
    logic             digit_ok;
    logic [7:0]       value;

    assign raw = {bus.key_enter, bus.key_push};

    // Debounced level follows the synced level only after it has
    // differed for DEBOUNCE_CYCLES consecutive clocks.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            db_d[i]  = db_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    db_d[i] = ~db_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            cnt_q[0]  <= '0;
            cnt_q[1]  <= '0;
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            cnt_q[0]  <= cnt_d[0];
            cnt_q[1]  <= cnt_d[1];
        end
    end

    assign press   = db_q & ~db_prev_q;
    // Enter takes priority: a coincident digit press is dropped silently.
    assign enter_p = press[1];
    assign push_p  = press[0] & ~press[1];

    assign digit_ok = (bus.key_digit <= 4'd9);
    assign value    = ({4'b0, tens_q} << 3) + ({4'b0, tens_q} << 1)
                    + {4'b0, ones_q};

    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        data_d  = data_q;
        ready_d = ready_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (push_p) begin
                    if (digit_ok) begin
                        tens_d  = 4'd0;
                        ones_d  = bus.key_digit;
                        err_d   = 1'b0;
                        state_d = S_ONE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_ONE: begin
                if (enter_p) begin
                    data_d  = value;
                    ready_d = 1'b1;
                    state_d = S_FULL;
                end else if (push_p) begin
                    if (digit_ok) begin
                        tens_d  = ones_q;
                        ones_d  = bus.key_digit;
                        err_d   = 1'b0;
                        state_d = S_TWO;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_TWO: begin
                if (enter_p) begin
                    data_d  = value;
                    ready_d = 1'b1;
                    state_d = S_FULL;
                end else if (push_p) begin
                    err_d = 1'b1;
                end
            end
            S_FULL: begin
                // data_out is held after consume until the next FULL entry.
                if (bus.li) begin
                    ready_d = 1'b0;
                    tens_d  = 4'd0;
                    ones_d  = 4'd0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tens_q  <= '0;
            ones_q  <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    assign bus.data_out = data_q;
    assign bus.ready    = ready_q;
    assign bus.err      = err_q;
    assign bus.disp_bcd = {tens_q, ones_q};

endmodule

// File: tb/tb_input_unit.sv
// tb_input_unit: directed + randomized bench for input_unit against a
// transaction-level model of the decimal entry behaviour.
module tb_input_unit;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    input_unit_if bus_if ();

    input_unit #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_pass = 0;
    int n_chk  = 0;

    // Model: digits entered so far, plus FULL/ready/err/data.
    int m_digits[$];
    bit m_full;
    int m_data;
    bit m_ready;
    bit m_err;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int m_tens();
        return (m_digits.size() == 2) ? m_digits[0] : 0;
    endfunction

    function automatic int m_ones();
        return (m_digits.size() >= 1) ? m_digits[m_digits.size()-1] : 0;
    endfunction

    task automatic model_reset();
        m_digits.delete();
        m_full  = 0;
        m_data  = 0;
        m_ready = 0;
        m_err   = 0;
    endtask

    task automatic model_push(int d);
        if (m_full) return;
        if (m_digits.size() == 2 || d > 9) m_err = 1;
        else begin
            m_digits.push_back(d);
            m_err = 0;
        end
    endtask

    task automatic model_enter();
        if (m_full || m_digits.size() == 0) return;
        m_data  = m_tens() * 10 + m_ones();
        m_ready = 1;
        m_full  = 1;
    endtask

    task automatic model_li();
        if (!m_full) return;
        m_full  = 0;
        m_ready = 0;
        m_digits.delete();
    endtask

    task automatic check_all(string tag);
        check({tag, "_data"},  bus_if.data_out, m_data);
        check({tag, "_ready"}, bus_if.ready,    m_ready);
        check({tag, "_err"},   bus_if.err,      m_err);
        check({tag, "_disp"},  bus_if.disp_bcd, m_tens() * 16 + m_ones());
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_digit(int d, int hold, int gap);
        bus_if.key_digit = 4'(d);
        bus_if.key_push  = 1'b1;
        step(hold);
        bus_if.key_push  = 1'b0;
        step(gap);
        model_push(d);
    endtask

    task automatic press_enter(int hold, int gap);
        bus_if.key_enter = 1'b1;
        step(hold);
        bus_if.key_enter = 1'b0;
        step(gap);
        model_enter();
    endtask

    task automatic pulse_li();
        bus_if.li = 1'b1;
        step(1);
        bus_if.li = 1'b0;
        step(1);
        model_li();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        bus_if.key_digit = 4'd0;
        bus_if.key_push  = 1'b0;
        bus_if.key_enter = 1'b0;
        bus_if.li        = 1'b0;
        rst              = 1'b1;
        model_reset();
        step(2);
        rst = 1'b0;
        step(20);
        check_all("reset");

        // 4, 2, enter, consume
        press_digit(4, 10, 10);
        press_digit(2, 10, 10);
        check("d42_disp", bus_if.disp_bcd, 8'h42);
        press_enter(10, 10);
        check("d42_data", bus_if.data_out, 8'h2A);
        check("d42_ready", bus_if.ready, 1'b1);
        bus_if.li = 1'b1;
        step(1);
        bus_if.li = 1'b0;
        model_li();
        check_all("d42_li");
        check("d42_keep", bus_if.data_out, 8'h2A);
        step(1);

        // Bounce then stable press, with accept-edge latency
        do_reset();
        bus_if.key_digit = 4'd7;
        repeat (3) begin
            bus_if.key_push = 1'b1;
            step(2);
            bus_if.key_push = 1'b0;
            step(4);
        end
        check("bounce_disp", bus_if.disp_bcd, 8'h00);
        bus_if.key_push = 1'b1;
        step(D + 2);
        check("lat_before", bus_if.disp_bcd, 8'h00);
        step(1);
        check("lat_at", bus_if.disp_bcd, 8'h07);
        step(10 - (D + 3));
        bus_if.key_push = 1'b0;
        step(10);
        model_push(7);
        check_all("bounce");

        // Invalid digit in IDLE, then recovery
        do_reset();
        press_digit(12, 10, 10);
        check_all("bad_idle");
        press_digit(9, 10, 10);
        press_enter(10, 10);
        check_all("nine");
        pulse_li();

        // Third digit rejected; enter+li together in FULL
        press_digit(1, 10, 10);
        press_digit(2, 10, 10);
        press_digit(3, 10, 10);
        check_all("third");
        press_enter(10, 10);
        check_all("d12");
        bus_if.key_enter = 1'b1;
        step(D + 2);
        bus_if.li = 1'b1;
        step(1);
        bus_if.li = 1'b0;
        model_li();
        step(10 - (D + 3));
        bus_if.key_enter = 1'b0;
        step(10);
        check_all("enter_li");

        // 99 -> 0x63
        press_digit(9, 10, 10);
        press_digit(9, 10, 10);
        press_enter(10, 10);
        check("d99", bus_if.data_out, 8'h63);
        pulse_li();

        // Enter and li while IDLE
        press_enter(10, 10);
        check_all("idle_enter");
        pulse_li();
        check_all("idle_li");

        // Reset in the middle of a held key_push debounce
        press_digit(3, 10, 10);
        press_digit(13, 10, 10);
        bus_if.key_digit = 4'd5;
        bus_if.key_push  = 1'b1;
        step(3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        model_reset();
        check_all("rst_mid");
        step(D + 2);
        check("rst_lat_before", bus_if.disp_bcd, 8'h00);
        step(1);
        check("rst_lat_at", bus_if.disp_bcd, 8'h05);
        step(3);
        bus_if.key_push = 1'b0;
        step(10);
        model_push(5);
        check_all("rst_press");

        // Randomized transactions
        for (int t = 0; t < 80; t++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 4) begin
                press_digit($urandom_range(0, 15),
                            $urandom_range(D + 2, D + 8),
                            $urandom_range(D + 4, D + 8));
            end else if (r <= 6) begin
                press_enter($urandom_range(D + 2, D + 8),
                            $urandom_range(D + 4, D + 8));
            end else begin
                pulse_li();
            end
            check_all("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/input_unit.md
Name: input_unit

Overview:
- Operator-side decimal entry front end for the 8-bit CPU; the counterpart of the 7-segment output unit.
- Takes a BCD digit from switches plus raw push-buttons, and synchronises and debounces the buttons.
- Accumulates up to two decimal digits and converts them to an 8-bit binary value.
- Offers that value to the CPU with a ready/li handshake; the CPU consumes it with an input-load strobe.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive clocks a synchronised button level must hold before the debounced level changes (synthesis builds use larger values).
CNT_W, 16, width of each debounce counter; DEBOUNCE_CYCLES must be < 2^CNT_W.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous active-high reset.
key_digit  in  4  BCD digit from switches; sampled on the press-accept edge; must be held stable while the button is pressed.
key_push  in  1  raw "digit" button, asynchronous, bouncy.
key_enter  in  1  raw "enter" button, asynchronous, bouncy.
li  in  1  CPU input-load strobe; consumes the value when ready=1.
data_out  out  8  binary value of the entered number.
ready  out  1  value valid, awaiting li.
err  out  1  sticky entry-error flag.
disp_bcd  out  8  {tens, ones} BCD echo of the digits entered, for display.

Behaviour:
- Reset (clk edge with rst=1):
  - data_out=0x00, ready=0, err=0, disp_bcd=0x00, state IDLE.
  - Synchroniser flops, debounced levels and counters all clear to 0.
  - rst overrides every other input that cycle.
- Synchroniser: each raw button passes through 2 flops.
- Debounce, per button:
  - Counter resets to 0 whenever synced == debounced.
  - Otherwise it increments each edge; on the edge where it equals DEBOUNCE_CYCLES-1, debounced toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES synced cycles never changes debounced.
  - A button held through reset registers as one press after reset, since debounced restarts at 0.
- Press pulse: combinational, debounced & ~debounced_prev; exactly one cycle per press. Release generates nothing.
- Latency: a raw rise sampled at edge 1 takes effect (digit/state update) at edge DEBOUNCE_CYCLES+3.
- FSM states: IDLE, ONE, TWO, FULL.
  - IDLE:
    - push with key_digit<=9: tens=0, ones=digit, err=0, go to ONE.
    - push with key_digit>9: err=1, stay.
    - enter: ignored.
  - ONE:
    - valid push: tens=ones, ones=digit, err=0, go to TWO.
    - invalid push: err=1, stay.
    - enter: go to FULL.
  - TWO:
    - any push: ignored, err=1.
    - enter: go to FULL.
  - FULL:
    - push and enter ignored; err unchanged.
    - li=1: ready=0 and tens=ones=0 on that edge, go to IDLE.
    - data_out keeps the consumed value until the next FULL entry.
- Entering FULL: data_out = tens*10+ones (computed as (tens<<3)+(tens<<1)+ones, max 99, zero-extended), ready=1. Both are registered on the same edge.
- li outside FULL: no effect.
- Simultaneous events:
  - Push and enter pulses in the same cycle: enter wins and the push is dropped (no err).
  - li and enter in FULL: li consumes and the enter is ignored.
- disp_bcd = {tens, ones} registered; it tracks the digit registers and clears on consume.
- err: cleared only by rst or by a valid digit accepted in IDLE/ONE.

Test Plan:
- Reset then idle 20 cycles -> data_out=0x00, ready=0, err=0, disp_bcd=0x00.
- Push digit 4, push digit 2 (clean, 10-cycle presses), enter -> disp_bcd=0x42, then ready=1 with data_out=0x2A. Pulse li 1 cycle -> ready=0 and disp_bcd=0x00 next edge; data_out stays 0x2A.
- Bounce on key_push: three 2-cycle pulses, then a stable 10-cycle press with digit 7 -> exactly one digit accepted, disp_bcd=0x07. Verify the accept edge is DEBOUNCE_CYCLES+3 after the stable rise.
- key_digit=0xC pushed in IDLE -> err=1, state IDLE, disp_bcd=0x00. Then push 9 and enter -> err=0, data_out=0x09, ready=1.
- Digits 1,2,3 then enter -> the third push sets err=1 with disp_bcd still 0x12; enter gives data_out=0x0C, ready=1. Enter and li asserted together in FULL -> single consume, ready=0.
- Boundaries:
  - Digits 9,9 + enter -> data_out=0x63.
  - Enter in IDLE -> no change.
  - li while IDLE -> no change.
  - rst asserted mid-debounce of a held key_push -> outputs cleared; one press is accepted DEBOUNCE_CYCLES+3 edges after rst deasserts.
